pc_ctrl: RTL and testbench

Fetch/execute sequencer for the 16-bit program counter `pc`. Fetches one instruction per step from instruction memory over a req/ack handshake and decodes it. Issues exactly one one-cycle PC command (`inc`, `add` or `sub` with `offset`) per instruction, and handles halt, resume and fetch time-out. Sits between the instruction-memory port and the `pc` block; `pc` output feeds back as the fetch address.

---
 rtl/pc_ctrl_pkg.sv | 31 +++
 rtl/pc_ctrl_decode.sv | 52 +++++
 rtl/pc_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the program-counter fetch/execute sequencer.
//   - opcode constants held in instruction bits [15:12]
//   - sequencer state enum
//   - one-hot PC command encoding {sub, add, inc}
package pc_ctrl_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_JF   = 4'h1;
    localparam logic [OP_W-1:0] OP_JB   = 4'h2;
    localparam logic [OP_W-1:0] OP_JFZ  = 4'h3;
    localparam logic [OP_W-1:0] OP_JBNZ = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Bit positions line up with the {pc_sub, pc_add, pc_inc} outputs.
    typedef enum logic [2:0] {
        CMD_NONE = 3'b000,
        CMD_INC  = 3'b001,
        CMD_ADD  = 3'b010,
        CMD_SUB  = 3'b100
    } pc_cmd_t;

endpackage

// File: rtl/pc_ctrl_decode.sv
// pc_ctrl_decode: purely combinational instruction decoder.
// Ports:
//   instr   in  PC_W  instruction register contents ([15:12] opcode, [11:0] imm)
//   zero    in  1     condition flag for the conditional jumps
//   inc/add/sub out 1 one-hot PC command (exactly one high for every opcode)
//   offset  out PC_W  zero-extended imm for add/sub, 0 for inc
//   is_halt out 1     HALT opcode
//   illegal out 1     undefined opcode (executes as inc)
module pc_ctrl_decode
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IMM_W = 12
) (
    input  logic [PC_W-1:0] instr,
    input  logic            zero,
    output logic            inc,
    output logic            add,
    output logic            sub,
    output logic [PC_W-1:0] offset,
    output logic            is_halt,
    output logic            illegal
);

    logic [OP_W-1:0] opcode;
    logic [PC_W-1:0] imm;
    pc_cmd_t         cmd;

    assign opcode = instr[PC_W-1 -: OP_W];
    assign imm    = PC_W'(instr[IMM_W-1:0]);

    always_comb begin
        cmd     = CMD_INC;
        is_halt = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_NOP:  cmd = CMD_INC;
            OP_JF:   cmd = CMD_ADD;
            OP_JB:   cmd = CMD_SUB;
            OP_JFZ:  cmd = zero ? CMD_ADD : CMD_INC;
            OP_JBNZ: cmd = zero ? CMD_INC : CMD_SUB;
            OP_HALT: is_halt = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign inc    = cmd[0];
    assign add    = cmd[1];
    assign sub    = cmd[2];
    assign offset = (cmd[1] | cmd[2]) ? imm : '0;

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch/execute sequencer driving the external pc block.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   run                   level, enables fetching from IDLE / after EXEC
//   resume                pulse, leaves HALT unless a fetch time-out occurred
//   zero                  condition flag, used during EXEC
//   pc                    current PC; passed straight through as imem_addr
//   imem_req/ack/data     instruction-memory handshake (ack may coincide with req)
//   pc_inc/add/sub        one-cycle one-hot PC command, issued in EXEC only
//   pc_offset             offset for add/sub, 0 otherwise
//   halted, fault         in HALT; sticky fetch time-out
//   illegal               one-cycle pulse in EXEC for an undefined opcode
//   icount                retired-instruction counter (wraps)
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int IMM_W   = 12,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            resume,
    input  logic            zero,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_data,
    output logic            pc_inc,
    output logic            pc_add,
    output logic            pc_sub,
    output logic [PC_W-1:0] pc_offset,
    output logic            halted,
    output logic            fault,
    output logic            illegal,
    output logic [15:0]     icount
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen during the last permitted ack-less FETCH cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   ir_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [15:0]       icount_reg;
    logic              fault_reg;

    logic              dec_inc, dec_add, dec_sub, dec_halt, dec_illegal;
    logic [PC_W-1:0]   dec_offset;
    logic              in_fetch, in_exec, fetch_done, timeout_hit;

    pc_ctrl_decode #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_decode (
        .instr   (ir_reg),
        .zero    (zero),
        .inc     (dec_inc),
        .add     (dec_add),
        .sub     (dec_sub),
        .offset  (dec_offset),
        .is_halt (dec_halt),
        .illegal (dec_illegal)
    );

    assign in_fetch    = (state_reg == FETCH);
    assign in_exec     = (state_reg == EXEC);
    assign fetch_done  = in_fetch && imem_ack;
    // An ack arriving in the final allowed cycle still wins over the time-out.
    assign timeout_hit = (TIMEOUT > 0) && in_fetch && !imem_ack && (wait_cnt_reg == WAIT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (run) state_next = FETCH;
            FETCH: begin
                if (imem_ack)         state_next = EXEC;
                else if (timeout_hit) state_next = HALT;
            end
            EXEC: begin
                if (dec_halt)  state_next = HALT;
                else if (run)  state_next = FETCH;
                else           state_next = IDLE;
            end
            HALT:  if (resume && !fault_reg) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: instruction register, wait counter, icount, fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_reg       <= '0;
            wait_cnt_reg <= '0;
            icount_reg   <= '0;
            fault_reg    <= 1'b0;
        end else begin
            if (fetch_done) begin
                ir_reg <= imem_data;
            end
            // Cleared outside ack-less FETCH, so every FETCH entry starts at 0.
            if (in_fetch && !imem_ack && !timeout_hit) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            if (in_exec) begin
                icount_reg <= icount_reg + 16'd1;
            end
            if (timeout_hit) begin
                fault_reg <= 1'b1;
            end
        end
    end

    // Output decode: everything but imem_addr derives from registered state,
    // so imem_ack never reaches the PC commands combinationally.
    always_comb begin
        imem_req  = in_fetch;
        halted    = (state_reg == HALT);
        pc_inc    = in_exec && dec_inc;
        pc_add    = in_exec && dec_add;
        pc_sub    = in_exec && dec_sub;
        pc_offset = in_exec ? dec_offset : '0;
        illegal   = in_exec && dec_illegal;
    end

    assign imem_addr = pc;
    assign fault     = fault_reg;
    assign icount    = icount_reg;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: bench for pc_ctrl with a behavioural pc block and an instruction
// memory whose ack latency is programmable (or withheld entirely).
// Expected PC commands are queued when each instruction is set up and compared
// when the DUT issues a command.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset, run, resume, zero;
    logic [15:0] pc, imem_addr, imem_data, pc_offset, icount;
    logic        imem_req, imem_ack, pc_inc, pc_add, pc_sub, halted, fault, illegal;

    int          n_cmp, n_mis;
    int          cyc = 0;
    logic [15:0] exp_icount;

    // {cmd[2:0] = {sub,add,inc}, offset[15:0], illegal, pc at EXEC[15:0]}
    logic [35:0] sb[$];
    int          stamps[$];

    localparam logic [2:0] C_INC = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_SUB = 3'b100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pc_ctrl #(
        .PC_W    (16),
        .IMM_W   (12),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .resume    (resume),
        .zero      (zero),
        .pc        (pc),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .pc_inc    (pc_inc),
        .pc_add    (pc_add),
        .pc_sub    (pc_sub),
        .pc_offset (pc_offset),
        .halted    (halted),
        .fault     (fault),
        .illegal   (illegal),
        .icount    (icount)
    );

    // Behavioural pc block
    always @(posedge clk or posedge reset) begin
        if (reset)       pc <= 16'h0000;
        else if (pc_inc) pc <= pc + 16'd1;
        else if (pc_add) pc <= pc + pc_offset;
        else if (pc_sub) pc <= pc - pc_offset;
    end

    // Behavioural instruction memory
    logic [15:0] mem [0:65535];
    int          ack_delay;
    logic        withhold;
    int          mem_wait;

    always @(posedge clk or posedge reset) begin
        if (reset)                      mem_wait <= 0;
        else if (imem_req && !imem_ack) mem_wait <= mem_wait + 1;
        else                            mem_wait <= 0;
    end
    assign imem_ack  = imem_req && !withhold && (mem_wait >= ack_delay);
    assign imem_data = mem[imem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Command monitor / scoreboard pop
    always @(negedge clk) begin
        logic [2:0]  c;
        logic [35:0] o;
        logic [35:0] e;
        if (!reset && (pc_inc || pc_add || pc_sub || illegal)) begin
            c = {pc_sub, pc_add, pc_inc};
            o = {c, pc_offset, illegal, pc};
            $display("txn cyc=%0d pc=%h cmd=%b off=%h ill=%b", cyc, pc, c, pc_offset, illegal);
            chk("cmd_onehot", 64'($countones(c) <= 1), 64'd1);
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'(o), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_cmd", 64'(o), 64'(e));
                stamps.push_back(cyc);
            end
        end
    end

    task automatic wait_sb_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Execute exactly one instruction: start via run (or resume from HALT),
    // drop the start signal during FETCH so the sequencer returns to IDLE.
    task automatic run_step(input logic [15:0] addr, input logic [15:0] instr, input logic z,
                            input logic [2:0] cmd, input logic [15:0] off, input logic ill,
                            input logic [15:0] pc_after, input logic via_resume);
        chk("pc_pre", 64'(pc), 64'(addr));
        mem[addr] = instr;
        zero      = z;
        sb.push_back({cmd, off, ill, addr});
        @(negedge clk);
        if (via_resume) resume = 1'b1;
        else            run    = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        run    = 1'b0;
        wait_sb_empty(20);
        @(negedge clk);
        chk("pc_after", 64'(pc), 64'(pc_after));
        exp_icount = exp_icount + 16'd1;
        chk("icount", 64'(icount), 64'(exp_icount));
    endtask

    // Four back-to-back NOPs with run held high; checks per-instruction period.
    task automatic run_burst(input int delay, input int period);
        logic [15:0] base;
        base      = pc;
        ack_delay = delay;
        for (int i = 0; i < 4; i++) begin
            mem[16'(base + 16'(i))] = 16'h0000;
            sb.push_back({C_INC, 16'h0000, 1'b0, 16'(base + 16'(i))});
        end
        stamps.delete();
        @(negedge clk);
        run = 1'b1;
        wait_sb_empty(60);
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("burst_pc", 64'(pc), 64'(16'(base + 16'd4)));
        exp_icount = exp_icount + 16'd4;
        chk("burst_icount", 64'(icount), 64'(exp_icount));
        if (stamps.size() == 4) chk("burst_period", 64'(stamps[3] - stamps[0]), 64'(3 * period));
        else                    chk("burst_stamps", 64'(stamps.size()), 64'd4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [15:0] pc_snap;

        n_cmp = 0;
        n_mis = 0;
        exp_icount = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        run = 1'b0; resume = 1'b0; zero = 1'b0;
        ack_delay = 0; withhold = 1'b0;
        reset = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_outs", 64'({imem_req, pc_inc, pc_add, pc_sub, pc_offset,
                               halted, fault, illegal, icount}), 64'd0);
        reset = 1'b0;

        // resume outside HALT, run low: stays idle
        @(negedge clk); resume = 1'b1;
        @(negedge clk); resume = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_req", 64'({imem_req, halted}), 64'd0);

        run_step(16'h0000, 16'h0000, 1'b0, C_INC, 16'h0000, 1'b0, 16'h0001, 1'b0);
        run_step(16'h0001, 16'h10A5, 1'b0, C_ADD, 16'h00A5, 1'b0, 16'h00A6, 1'b0);
        run_step(16'h00A6, 16'h0000, 1'b0, C_INC, 16'h0000, 1'b0, 16'h00A7, 1'b0);
        run_step(16'h00A7, 16'h2014, 1'b0, C_SUB, 16'h0014, 1'b0, 16'h0093, 1'b0);
        run_step(16'h0093, 16'h3010, 1'b0, C_INC, 16'h0000, 1'b0, 16'h0094, 1'b0);
        run_step(16'h0094, 16'h2001, 1'b0, C_SUB, 16'h0001, 1'b0, 16'h0093, 1'b0);
        run_step(16'h0093, 16'h3010, 1'b1, C_ADD, 16'h0010, 1'b0, 16'h00A3, 1'b0);
        run_step(16'h00A3, 16'h7123, 1'b0, C_INC, 16'h0000, 1'b1, 16'h00A4, 1'b0);
        run_step(16'h00A4, 16'h4005, 1'b0, C_SUB, 16'h0005, 1'b0, 16'h009F, 1'b0);
        run_step(16'h009F, 16'h4005, 1'b1, C_INC, 16'h0000, 1'b0, 16'h00A0, 1'b0);
        run_step(16'h00A0, 16'h1000, 1'b0, C_ADD, 16'h0000, 1'b0, 16'h00A0, 1'b0);
        run_step(16'h00A0, 16'h2090, 1'b0, C_SUB, 16'h0090, 1'b0, 16'h0010, 1'b0);

        // HALT: no requests even with run high
        run_step(16'h0010, 16'hF000, 1'b0, C_INC, 16'h0000, 1'b0, 16'h0011, 1'b0);
        chk("halt_halted", 64'(halted), 64'd1);
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt_no_req", 64'(imem_req), 64'd0);
        run = 1'b0;

        // resume fetches from 0011; JB with large imm wraps below zero
        run_step(16'h0011, 16'h2FFF, 1'b0, C_SUB, 16'h0FFF, 1'b0, 16'hF012, 1'b1);
        chk("resume_unhalt", 64'(halted), 64'd0);
        run_step(16'hF012, 16'hE000, 1'b0, C_INC, 16'h0000, 1'b1, 16'hF013, 1'b0);

        run_burst(0, 2);
        run_burst(3, 5);
        ack_delay = 0;

        // Fetch time-out
        withhold = 1'b1;
        pc_snap  = pc;
        @(negedge clk); run = 1'b1;
        n = 0;
        @(negedge clk);
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", 64'(n), 64'd15);
        chk("timeout_state", 64'({fault, halted, imem_req}), 64'b110);
        chk("timeout_pc", 64'(pc), 64'(pc_snap));
        chk("timeout_icount", 64'(icount), 64'(exp_icount));
        run = 1'b0;
        @(negedge clk); resume = 1'b1;
        @(negedge clk); resume = 1'b0;
        repeat (3) @(negedge clk);
        chk("fault_resume_ignored", 64'({fault, halted, imem_req}), 64'b110);

        // reset clears fault
        #2 reset = 1'b1;
        #1;
        chk("reset_clears_fault", 64'({fault, halted, icount}), 64'd0);
        @(negedge clk); reset = 1'b0;
        exp_icount = 16'h0000;
        withhold   = 1'b0;

        // One instruction so icount is nonzero, then reset mid-FETCH
        run_step(16'h0000, 16'h0000, 1'b0, C_INC, 16'h0000, 1'b0, 16'h0001, 1'b0);
        withhold = 1'b1;
        @(negedge clk); run = 1'b1;
        repeat (3) @(negedge clk);
        chk("midfetch_req", 64'(imem_req), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_req_drop", 64'(imem_req), 64'd0);
        chk("async_clear", 64'({fault, icount}), 64'd0);
        run = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
